// File: rtl/tmr_hamming_scrub_bank.sv
// Triple-redundant Hamming(7,4) storage cell: voted and corrected read, periodic scrub with
// write-back, saturating correction telemetry and an SEU fault-injection port.
module tmr_hamming_scrub_bank #(
    parameter int SCRUB_PERIOD = 256,
    parameter int CNT_W        = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [3:0]       wr_data_i,
    output logic             wr_ready_o,
    input  logic             inj_en_i,
    input  logic [1:0]       inj_copy_i,
    input  logic [6:0]       inj_mask_i,
    input  logic             clr_cnt_i,
    output logic [3:0]       rd_data_o,
    output logic             rd_valid_o,
    output logic [CNT_W-1:0] corr_cnt_o,
    output logic             err_flag_o,
    output logic             scrub_busy_o
);
    localparam int               TMR_W    = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCRUB_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    function automatic logic [6:0] hamming_enc(input logic [3:0] d);
        return {d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0], d[3],
                d[2] ^ d[1] ^ d[0], d[2], d[1], d[0]};
    endfunction

    function automatic logic [2:0] hamming_syn(input logic [6:0] v);
        return {v[3] ^ v[2] ^ v[1] ^ v[0],
                v[5] ^ v[4] ^ v[1] ^ v[0],
                v[6] ^ v[4] ^ v[2] ^ v[0]};
    endfunction

    function automatic logic [6:0] hamming_fix(input logic [6:0] v);
        logic [6:0] flip;
        case (hamming_syn(v))
            3'b001:  flip = 7'b100_0000;
            3'b010:  flip = 7'b010_0000;
            3'b011:  flip = 7'b001_0000;
            3'b100:  flip = 7'b000_1000;
            3'b101:  flip = 7'b000_0100;
            3'b110:  flip = 7'b000_0010;
            3'b111:  flip = 7'b000_0001;
            default: flip = 7'b000_0000;
        endcase
        return v ^ flip;
    endfunction

    function automatic logic [6:0] vote3(input logic [6:0] a, input logic [6:0] b,
                                         input logic [6:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CHK = 2'd1, ST_WB = 2'd2} state_t;

    state_t           state_q;
    logic [2:0][6:0]  copy_q, copy_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d;
    logic [3:0]       rd_q, rd_d;
    logic             pending_q, wr_ready_q, busy_q;
    logic [6:0]       k_q;
    logic             syn_nz_q, mismatch_q;

    logic [6:0]       vote_s, fix_s;
    logic [2:0]       syn_s;
    logic             wr_fire_s, timer_hit_s, scrub_go_s;

    assign vote_s      = vote3(copy_q[0], copy_q[1], copy_q[2]);
    assign syn_s       = hamming_syn(vote_s);
    assign fix_s       = hamming_fix(vote_s);
    assign wr_fire_s   = wr_en_i && (state_q == ST_IDLE);
    assign timer_hit_s = (timer_q == TMR_LAST);
    // A write in the same idle cycle takes precedence; the request stays pending.
    assign scrub_go_s  = (state_q == ST_IDLE) && pending_q && !wr_en_i;

    // Next-state for the storage copies, telemetry, timer and read register.
    always_comb begin
        copy_d  = copy_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        valid_d = valid_q;
        timer_d = timer_hit_s ? {TMR_W{1'b0}} : timer_q + TMR_W'(1);
        rd_d    = {fix_s[4], fix_s[2], fix_s[1], fix_s[0]};

        if (state_q == ST_WB) begin
            copy_d = {3{k_q}};
        end else if (wr_fire_s) begin
            copy_d  = {3{hamming_enc(wr_data_i)}};
            valid_d = 1'b1;
        end else if (inj_en_i) begin
            case (inj_copy_i)
                2'd0:    copy_d[0] = copy_q[0] ^ inj_mask_i;
                2'd1:    copy_d[1] = copy_q[1] ^ inj_mask_i;
                2'd2:    copy_d[2] = copy_q[2] ^ inj_mask_i;
                default: copy_d    = copy_q;
            endcase
        end else begin
            copy_d = copy_q;
        end

        if (clr_cnt_i) begin
            cnt_d = {CNT_W{1'b0}};
            err_d = 1'b0;
        end else if (state_q == ST_WB) begin
            cnt_d = (mismatch_q && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
            err_d = err_q | syn_nz_q;
        end else begin
            cnt_d = cnt_q;
            err_d = err_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            copy_q  <= {3{7'h00}};
            timer_q <= {TMR_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            rd_q    <= 4'h0;
        end else begin
            copy_q  <= copy_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            rd_q    <= rd_d;
        end
    end

    // Scrub sequencer with its request latch, check snapshot and registered status outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            pending_q  <= 1'b0;
            wr_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            k_q        <= 7'h00;
            syn_nz_q   <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            if (timer_hit_s) begin
                pending_q <= 1'b1;
            end else if (scrub_go_s) begin
                pending_q <= 1'b0;
            end else begin
                pending_q <= pending_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (scrub_go_s) begin
                        state_q    <= ST_CHK;
                        wr_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q    <= ST_IDLE;
                        wr_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                end
                ST_CHK: begin
                    k_q        <= fix_s;
                    syn_nz_q   <= (syn_s != 3'b000);
                    mismatch_q <= (copy_q[0] != fix_s) || (copy_q[1] != fix_s) ||
                                  (copy_q[2] != fix_s);
                    state_q    <= ST_WB;
                    wr_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                end
                ST_WB: begin
                    state_q    <= ST_IDLE;
                    wr_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    wr_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready_o   = wr_ready_q;
    assign scrub_busy_o = busy_q;
    assign rd_data_o    = rd_q;
    assign rd_valid_o   = valid_q;
    assign corr_cnt_o   = cnt_q;
    assign err_flag_o   = err_q;

endmodule

// File: tb/tb_tmr_hamming_scrub_bank.sv
// Randomized scenario bench for tmr_hamming_scrub_bank; the reference decodes by nearest-codeword
// search over all 16 data values and tracks the three copies as a plain array.
module tb_tmr_hamming_scrub_bank;
    localparam int P     = 16;
    localparam int CNT_W = 2;
    localparam int CMAX  = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [3:0]       wr_data;
    logic             wr_ready;
    logic             inj_en;
    logic [1:0]       inj_copy;
    logic [6:0]       inj_mask;
    logic             clr_cnt;
    logic [3:0]       rd_data;
    logic             rd_valid;
    logic [CNT_W-1:0] corr_cnt;
    logic             err_flag;
    logic             scrub_busy;

    always #5 clk = ~clk;

    tmr_hamming_scrub_bank #(.SCRUB_PERIOD(P), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
        .inj_en_i(inj_en), .inj_copy_i(inj_copy), .inj_mask_i(inj_mask), .clr_cnt_i(clr_cnt),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .corr_cnt_o(corr_cnt),
        .err_flag_o(err_flag), .scrub_busy_o(scrub_busy)
    );

    int         checks = 0;
    int         passes = 0;
    int         cyc    = 0;
    logic [6:0] m_copy [3];
    int         m_cnt;
    logic       m_err;
    logic       m_valid;

    function automatic logic [6:0] m_enc(input logic [3:0] d);
        logic [6:0] c;
        c[0] = d[0]; c[1] = d[1]; c[2] = d[2]; c[4] = d[3];
        c[3] = d[2] ^ d[1] ^ d[0];
        c[5] = d[3] ^ d[1] ^ d[0];
        c[6] = d[3] ^ d[2] ^ d[0];
        return c;
    endfunction

    function automatic logic [6:0] m_maj(input logic [6:0] a, input logic [6:0] b,
                                         input logic [6:0] c);
        logic [6:0] r;
        for (int i = 0; i < 7; i++) r[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
        return r;
    endfunction

    // Hamming(7,4) is perfect: exactly one codeword lies within distance 1 of any word.
    function automatic logic [3:0] m_decode(input logic [6:0] v);
        logic [3:0] r;
        r = 4'h0;
        for (int d = 0; d < 16; d++)
            if ($countones(m_enc(4'(d)) ^ v) <= 1) r = 4'(d);
        return r;
    endfunction

    function automatic logic [3:0] m_read();
        return m_decode(m_maj(m_copy[0], m_copy[1], m_copy[2]));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_copy[i] = 7'h00;
        m_cnt = 0; m_err = 1'b0; m_valid = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] d);
        wr_en = 1'b1; wr_data = d;
        tick();
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) m_copy[i] = m_enc(d);
        m_valid = 1'b1;
    endtask

    task automatic do_inject(input logic [1:0] c, input logic [6:0] m);
        inj_en = 1'b1; inj_copy = c; inj_mask = m;
        tick();
        inj_en = 1'b0;
        if (c != 2'd3) m_copy[c] = m_copy[c] ^ m;
    endtask

    task automatic do_clr();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        m_cnt = 0; m_err = 1'b0;
    endtask

    task automatic wait_scrub();
        int exp_cyc;
        logic [6:0] v, k;
        logic mis, nz;
        exp_cyc = ((cyc + P - 1) / P) * P + 1;
        while (scrub_busy !== 1'b1 && cyc < exp_cyc + 2 * P) tick();
        checks++;
        if (cyc !== exp_cyc) $display("FAIL scrub_start: cycle %0d expected %0d", cyc, exp_cyc);
        else passes++;
        checks++;
        if (wr_ready !== 1'b0) $display("FAIL ready_in_chk: got %b expected 0", wr_ready);
        else passes++;
        v   = m_maj(m_copy[0], m_copy[1], m_copy[2]);
        k   = m_enc(m_decode(v));
        mis = (m_copy[0] != k) || (m_copy[1] != k) || (m_copy[2] != k);
        nz  = (v != k);
        tick();
        checks++;
        if (scrub_busy !== 1'b1) $display("FAIL busy_in_wb: got %b expected 1", scrub_busy);
        else passes++;
        tick();
        for (int i = 0; i < 3; i++) m_copy[i] = k;
        if (mis && m_cnt < CMAX) m_cnt++;
        if (nz) m_err = 1'b1;
        checks++;
        if (scrub_busy !== 1'b0 || wr_ready !== 1'b1)
            $display("FAIL scrub_end: busy %b ready %b expected 0 1", scrub_busy, wr_ready);
        else passes++;
        checks++;
        if (corr_cnt !== CNT_W'(m_cnt)) $display("FAIL corr_cnt: got %0d expected %0d", corr_cnt, m_cnt);
        else passes++;
        checks++;
        if (err_flag !== m_err) $display("FAIL err_flag: got %b expected %b", err_flag, m_err);
        else passes++;
        tick();
        checks++;
        if (rd_data !== m_read()) $display("FAIL rd_after_scrub: got %h expected %h", rd_data, m_read());
        else passes++;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (rd_data !== 4'h0 || rd_valid !== 1'b0 || corr_cnt !== '0 || err_flag !== 1'b0 ||
            wr_ready !== 1'b1 || scrub_busy !== 1'b0)
            $display("FAIL %s: rd %h valid %b cnt %0d err %b ready %b busy %b expected 0 0 0 0 1 0",
                     tag, rd_data, rd_valid, corr_cnt, err_flag, wr_ready, scrub_busy);
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_data = 4'h0; inj_en = 1'b0; inj_copy = 2'd0;
        inj_mask = 7'h00; clr_cnt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst = 1'b0; cyc = 0;
        model_reset();
    endtask

    task automatic test_write();
        logic [3:0] prev;
        prev = m_read();
        do_write(4'hA);
        checks++;
        if (rd_valid !== 1'b1) $display("FAIL rd_valid_after_write: got %b expected 1", rd_valid);
        else passes++;
        checks++;
        if (rd_data !== prev) $display("FAIL rd_latency: got %h expected %h", rd_data, prev);
        else passes++;
        tick();
        checks++;
        if (rd_data !== 4'hA) $display("FAIL rd_after_write: got %h expected a", rd_data);
        else passes++;
        wait_scrub();
    endtask

    task automatic test_tmr_single_copy();
        do_clr();
        do_write(4'h5);
        do_inject(2'd1, 7'h7F);
        tick();
        checks++;
        if (rd_data !== m_read()) $display("FAIL tmr_mask: got %h expected %h", rd_data, m_read());
        else passes++;
        wait_scrub();
        do_inject(2'd0, 7'h7F);
        tick();
        checks++;
        if (rd_data !== 4'h5) $display("FAIL copy1_restored: got %h expected 5", rd_data);
        else passes++;
        wait_scrub();
    endtask

    task automatic test_hamming_correct();
        do_clr();
        do_write(4'h3);
        do_inject(2'd0, 7'h01);
        do_inject(2'd2, 7'h01);
        tick();
        checks++;
        if (rd_data !== 4'h3) $display("FAIL hamming_read: got %h expected 3", rd_data);
        else passes++;
        wait_scrub();
        do_clr();
        checks++;
        if (corr_cnt !== '0 || err_flag !== 1'b0)
            $display("FAIL clr_cnt: cnt %0d err %b expected 0 0", corr_cnt, err_flag);
        else passes++;
        do_inject(2'd1, 7'h7F);
        tick();
        checks++;
        if (rd_data !== 4'h3) $display("FAIL all_copies_rewritten: got %h expected 3", rd_data);
        else passes++;
        wait_scrub();
    endtask

    task automatic test_back_to_back();
        logic [3:0] d1;
        logic [6:0] k;
        d1 = 4'($urandom_range(0, 15));
        for (int i = 0; i < P && (cyc % P) != 0; i++) tick();
        do_write(d1);
        checks++;
        if (scrub_busy !== 1'b0 || wr_ready !== 1'b1)
            $display("FAIL write_wins: busy %b ready %b expected 0 1", scrub_busy, wr_ready);
        else passes++;
        k = m_enc(d1);
        tick();
        checks++;
        if (scrub_busy !== 1'b1) $display("FAIL chk_after_write: got %b expected 1", scrub_busy);
        else passes++;
        checks++;
        if (rd_data !== d1) $display("FAIL hit_write_data: got %h expected %h", rd_data, d1);
        else passes++;
        wr_en = 1'b1; wr_data = ~d1;
        tick();
        checks++;
        if (wr_ready !== 1'b0) $display("FAIL ready_in_wb: got %b expected 0", wr_ready);
        else passes++;
        inj_en = 1'b1; inj_copy = 2'd0; inj_mask = 7'h7F;
        tick();
        wr_en = 1'b0; inj_en = 1'b0;
        for (int i = 0; i < 3; i++) m_copy[i] = k;
        checks++;
        if (corr_cnt !== CNT_W'(m_cnt) || wr_ready !== 1'b1)
            $display("FAIL b2b_end: cnt %0d ready %b expected %0d 1", corr_cnt, wr_ready, m_cnt);
        else passes++;
        tick();
        checks++;
        if (rd_data !== d1) $display("FAIL write_blocked: got %h expected %h", rd_data, d1);
        else passes++;
        do_inject(2'd1, 7'h7F);
        tick();
        checks++;
        if (rd_data !== d1) $display("FAIL inj_dropped_in_wb: got %h expected %h", rd_data, d1);
        else passes++;
        wait_scrub();
    endtask

    task automatic test_saturation();
        int n;
        logic [6:0] k;
        do_clr();
        for (int i = 0; i < 5; i++) begin
            do_inject(2'($urandom_range(0, 2)), 7'($urandom_range(1, 127)));
            wait_scrub();
        end
        checks++;
        if (corr_cnt !== 2'd3) $display("FAIL saturate: got %0d expected 3", corr_cnt);
        else passes++;
        do_inject(2'd0, 7'h10);
        n = 0;
        while (scrub_busy !== 1'b1 && n < 2 * P) begin tick(); n++; end
        checks++;
        if (scrub_busy !== 1'b1) $display("FAIL sat_scrub_timeout: busy %b expected 1", scrub_busy);
        else passes++;
        k = m_enc(m_read());
        tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        for (int i = 0; i < 3; i++) m_copy[i] = k;
        m_cnt = 0; m_err = 1'b0;
        checks++;
        if (corr_cnt !== '0 || err_flag !== 1'b0)
            $display("FAIL clr_beats_inc: cnt %0d err %b expected 0 0", corr_cnt, err_flag);
        else passes++;
        tick();
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 1) == 1) do_clr();
            do_write(4'($urandom_range(0, 15)));
            for (int j = 0; j < int'($urandom_range(0, 2)); j++)
                do_inject(2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)));
            tick();
            checks++;
            if (rd_data !== m_read()) $display("FAIL rand_read: got %h expected %h", rd_data, m_read());
            else passes++;
            checks++;
            if (rd_valid !== m_valid) $display("FAIL rand_valid: got %b expected %b", rd_valid, m_valid);
            else passes++;
            wait_scrub();
        end
    endtask

    task automatic test_reset_mid_scrub();
        int n;
        do_inject(2'd2, 7'h7F);
        n = 0;
        while (scrub_busy !== 1'b1 && n < 2 * P) begin tick(); n++; end
        checks++;
        if (scrub_busy !== 1'b1) $display("FAIL rst_scrub_timeout: busy %b expected 1", scrub_busy);
        else passes++;
        tick();
        rst = 1'b1;
        #2;
        check_reset_outputs("reset_in_wb");
        @(posedge clk);
        #1;
        rst = 1'b0; cyc = 0;
        model_reset();
        tick();
        checks++;
        if (rd_data !== 4'h0 || rd_valid !== 1'b0)
            $display("FAIL copies_cleared: rd %h valid %b expected 0 0", rd_data, rd_valid);
        else passes++;
        wait_scrub();
    endtask

    initial begin
        test_reset();
        test_write();
        test_tmr_single_copy();
        test_hamming_correct();
        test_back_to_back();
        test_saturation();
        test_random();
        test_reset_mid_scrub();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
